// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg -- shared definitions for the piso_tx serializer.
//
// Contents:
//   state_t        FSM state encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH  default parallel word width
//   cnt_width()    width of the frame bit counter for a given word width
// -----------------------------------------------------------------------------
package piso_pkg;

  // Two-state transmitter FSM.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default parallel word width.
  localparam int DEFAULT_WIDTH = 8;

  // The counter is sized for WIDTH+2 so that it can represent every index of
  // a parity-extended frame (0..WIDTH) without ever wrapping inside a frame.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage : piso_pkg

// File: rtl/piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg -- loadable shift register feeding the serial output.
//
// The bit presented on sout is a register bit, so the serial output of the
// transmitter is registered without a further pipeline stage. Vacated
// positions are filled with zeros, so after a full frame of shifts the
// register (and therefore sout) is zero.
//
// Parameters:
//   SW         register width (frame length, data plus optional parity)
//   LSB_FIRST  0: bit SW-1 leaves first (shift left)
//              1: bit 0 leaves first (shift right)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset, clears the register
//   load       parallel load of load_data (has priority over shift)
//   shift      advance by one bit
//   load_data  parallel word to load
//   sout       bit currently being transmitted
// -----------------------------------------------------------------------------
module piso_shreg #(
  parameter int SW        = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [SW-1:0] load_data,
  output logic          sout
);

  logic [SW-1:0] data_q;

  // NOTE: the data register is reset as well, not just the control state, so
  // an aborted word can never leak onto sout and the idle output is a clean 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      if (LSB_FIRST) begin
        data_q <= {1'b0, data_q[SW-1:1]};
      end else begin
        data_q <= {data_q[SW-2:0], 1'b0};
      end
    end
  end

  assign sout = LSB_FIRST ? data_q[0] : data_q[SW-1];

endmodule : piso_shreg

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out frame transmitter.
//
// A word is accepted on a rising edge where in_valid and in_ready are both
// high. Its bits then leave on sd, one per cycle, starting in the cycle after
// the accept edge. in_ready is high while idle and during the last bit of a
// frame, so a waiting word follows the previous frame with no gap.
//
// Optional feature (compile-time macro):
//   PISO_TX_PARITY_EN  when defined, an even-parity bit (XOR of all data
//                      bits) is appended after the data bits and a frame is
//                      WIDTH+1 cycles long; otherwise a frame is WIDTH cycles
//                      and no parity logic exists.
//
// Parameters:
//   WIDTH      parallel word width, 2..32
//   LSB_FIRST  0: MSB transmitted first, 1: LSB transmitted first
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; aborts any frame in progress
//   in_data    parallel word to serialize
//   in_valid   in_data is valid
//   in_ready   combinational; the block accepts a word this cycle
//   sd         registered serial data
//   sd_valid   registered; high while sd carries a frame bit
//   sd_first   registered; high only on the first bit of each frame
// -----------------------------------------------------------------------------
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sd,
  output logic             sd_valid,
  output logic             sd_first
);

`ifdef PISO_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int FLEN = WIDTH + PAR_BITS;
  localparam int CW   = cnt_width(WIDTH);

  localparam logic [CW-1:0] LAST_IDX = CW'(FLEN - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sd_valid_q;
  logic          sd_first_q;

  logic          last_bit;
  logic          xfer;
  logic          load;
  logic          shift;
  logic [FLEN-1:0] load_word;

  // ---------------------------------------------------------------------------
  // Frame word: data bits plus, optionally, the parity bit placed so that it
  // leaves the shift register after all data bits in either direction.
  // ---------------------------------------------------------------------------
`ifdef PISO_TX_PARITY_EN
  logic parity;

  assign parity    = ^in_data;
  assign load_word = LSB_FIRST ? {parity, in_data} : {in_data, parity};
`else
  assign load_word = in_data;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;

    last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    in_ready = (state_q == IDLE) || last_bit;
    xfer     = in_valid && in_ready;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end

      SHIFT: begin
        if (xfer) begin
          // Accepted in the last bit cycle: next frame starts without a gap.
          cnt_d = '0;
          load  = 1'b1;
        end else if (last_bit) begin
          // The final shift empties the register, so sd returns to 0.
          state_d = IDLE;
          cnt_d   = '0;
          shift   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          shift = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and output flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sd_valid_q <= 1'b0;
      sd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sd_valid_q <= (state_d == SHIFT);
      sd_first_q <= load;
    end
  end

  assign sd_valid = sd_valid_q;
  assign sd_first = sd_first_q;

  // ---------------------------------------------------------------------------
  // Shift register
  // ---------------------------------------------------------------------------
  piso_shreg #(
    .SW        (FLEN),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (load_word),
    .sout      (sd)
  );

endmodule : piso_tx

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0: 0 = MSB transmitted first, 1 = LSB transmitted first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 sd  output  1  registered serial data; drives the downstream serial shift-register input d.
REQ-009 sd_valid  output  1  registered; high while sd carries a frame bit.
REQ-010 sd_first  output  1  registered; high only on the first bit of each frame.

Function
REQ-011 The block SHALL use a two-state FSM, IDLE and SHIFT.
REQ-012 A transfer SHALL occur at a rising edge where in_valid and in_ready are both high.
REQ-013 in_ready SHALL be combinational: high in IDLE, and high in SHIFT only during the last bit cycle of the frame.
REQ-014 On a transfer, the block SHALL load the word and enter SHIFT; the first bit SHALL appear on sd with sd_valid=1 and sd_first=1 in the cycle after the transfer edge.
REQ-015 In SHIFT, the block SHALL advance one bit per cycle; a frame SHALL be FLEN consecutive cycles, with FLEN=WIDTH (parity disabled) or WIDTH+1 (parity enabled).
REQ-016 The bit counter SHALL be $clog2(WIDTH+2) bits wide, count 0..FLEN-1, and must not wrap within a frame.
REQ-017 A transfer in the last bit cycle SHALL start the next frame in the following cycle, with no idle gap and sd_first=1.
REQ-018 After the last bit with no transfer, the block SHALL return to IDLE with sd=0, sd_valid=0 and sd_first=0.
REQ-019 in_data changes while in_ready=0 SHALL not affect the frame in progress.
REQ-020 in_valid deasserted mid-frame SHALL have no effect on the frame in progress.

Reset
REQ-021 While rst=1, the block SHALL be in IDLE with sd=0, sd_valid=0, sd_first=0, counter=0 and shift register=0; in_ready SHALL therefore be high.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clock edge; the aborted word SHALL be discarded.
REQ-023 The first transfer SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-024 Macro PISO_TX_PARITY_EN defined: one even-parity bit (XOR of all WIDTH data bits) SHALL be transmitted after the data bits, and FLEN=WIDTH+1.
REQ-025 Macro PISO_TX_PARITY_EN undefined: no parity bit and no parity logic; FLEN=WIDTH.

Structure
REQ-026 Package piso_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-027 Sub-module piso_shreg SHALL hold the loadable shift register (parallel load, shift direction from LSB_FIRST, async active-high reset); piso_tx SHALL hold the FSM, counter and parity logic.

Verification
REQ-028 Reset: rst=1 for 2 cycles, then release -> sd=0, sd_valid=0, in_ready=1.
REQ-029 Single word: WIDTH=8, LSB_FIRST=0, 8'hA5 -> sd = 1,0,1,0,0,1,0,1; sd_valid high for 8 cycles; sd_first only on the first bit.
REQ-030 Back-to-back: 8'hC3, then 8'h5A with in_valid held high -> 16 contiguous sd_valid cycles; sd = 11000011 then 01011010; sd_first in cycles 1 and 9.
REQ-031 Stall: present 8'hF0 and change in_data each cycle while busy -> in_ready low for cycles 1-7 of the frame; the serialized word is unchanged.
REQ-032 Abort: assert rst after the 3rd bit of 8'hFF -> sd and sd_valid fall to 0 asynchronously; the next word 8'h81 serializes correctly.
REQ-033 Options: LSB_FIRST=1, 8'h01 -> sd = 1,0,0,0,0,0,0,0; with PISO_TX_PARITY_EN defined, 8'h07 -> parity bit 1 as the 9th bit.
